// File: rtl/cp0_reg.sv
// Coprocessor-0 privileged register file: Count/Compare timer, Status, Cause, EPC, BadVAddr, PRId, Config.
// Optional timer interrupt enabled by defining CP0_TIMER_INT_EN (default: timer_int_o tied low).
module cp0_reg #(
    parameter logic [31:0] PRID_VALUE   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VALUE = 32'h0000_8000,
    parameter int unsigned COUNT_DIV    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] data_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] data_o,
    input  logic [5:0]  int_i,
    input  logic        exc_valid_i,
    input  logic [4:0]  exc_code_i,
    input  logic [31:0] exc_pc_i,
    input  logic        exc_in_ds_i,
    input  logic [31:0] bad_vaddr_i,
    input  logic        eret_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o
);

    localparam logic [4:0]  ADDR_BADVADDR = 5'd8;
    localparam logic [4:0]  ADDR_COUNT    = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE  = 5'd11;
    localparam logic [4:0]  ADDR_STATUS   = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE    = 5'd13;
    localparam logic [4:0]  ADDR_EPC      = 5'd14;
    localparam logic [4:0]  ADDR_PRID     = 5'd15;
    localparam logic [4:0]  ADDR_CONFIG   = 5'd16;

    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
    localparam logic        DIV_BY_ONE   = (COUNT_DIV == 1);

    logic [31:0] count_reg, count_next;
    logic [31:0] compare_reg, compare_next;
    logic [31:0] status_reg, status_next;
    logic [31:0] cause_reg, cause_next;
    logic [31:0] epc_reg, epc_next;
    logic [31:0] badvaddr_reg, badvaddr_next;
    logic        phase_reg, phase_next;
    logic        timer_int_reg, timer_int_next;

    logic mtc0_en;
    logic wr_count, wr_compare, wr_status, wr_cause, wr_epc;
    logic old_exl;

    // A committing exception or ERET squashes the MTC0 in the same cycle.
    assign mtc0_en    = we_i & ~exc_valid_i & ~eret_i;
    assign wr_count   = mtc0_en && (waddr_i == ADDR_COUNT);
    assign wr_compare = mtc0_en && (waddr_i == ADDR_COMPARE);
    assign wr_status  = mtc0_en && (waddr_i == ADDR_STATUS);
    assign wr_cause   = mtc0_en && (waddr_i == ADDR_CAUSE);
    assign wr_epc     = mtc0_en && (waddr_i == ADDR_EPC);
    assign old_exl    = status_reg[1];

    always_comb begin
        count_next = count_reg;
        phase_next = phase_reg;
        if (wr_count) begin
            count_next = data_i;
            phase_next = 1'b0;
        end else if (DIV_BY_ONE || phase_reg) begin
            count_next = count_reg + 32'd1;
            phase_next = 1'b0;
        end else begin
            phase_next = 1'b1;
        end
    end

    assign compare_next = wr_compare ? data_i : compare_reg;

`ifdef CP0_TIMER_INT_EN
    always_comb begin
        timer_int_next = timer_int_reg;
        if (wr_compare)
            timer_int_next = 1'b0;
        else if ((count_reg == compare_reg) && (compare_reg != 32'd0))
            timer_int_next = 1'b1;
    end
`else
    assign timer_int_next = 1'b0;
`endif

    always_comb begin
        status_next = status_reg;
        if (exc_valid_i)
            status_next[1] = 1'b1;
        else if (eret_i)
            status_next[1] = 1'b0;
        else if (wr_status)
            status_next = (status_reg & ~STATUS_WMASK) | (data_i & STATUS_WMASK);
    end

    always_comb begin
        cause_next = cause_reg;
        if (exc_valid_i) begin
            cause_next[6:2] = exc_code_i;
            if (!old_exl)
                cause_next[31] = exc_in_ds_i;
        end else if (wr_cause) begin
            cause_next[9:8] = data_i[9:8];
        end
        // timer_int_reg is constant 0 when the timer interrupt is compiled out.
        cause_next[15:10] = {int_i[5] | timer_int_reg, int_i[4:0]};
    end

    always_comb begin
        epc_next      = epc_reg;
        badvaddr_next = badvaddr_reg;
        if (exc_valid_i) begin
            if (!old_exl)
                epc_next = exc_in_ds_i ? (exc_pc_i - 32'd4) : exc_pc_i;
            if ((exc_code_i == 5'd4) || (exc_code_i == 5'd5))
                badvaddr_next = bad_vaddr_i;
        end else if (wr_epc) begin
            epc_next = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg     <= '0;
            compare_reg   <= '0;
            status_reg    <= STATUS_RESET;
            cause_reg     <= '0;
            epc_reg       <= '0;
            badvaddr_reg  <= '0;
            phase_reg     <= 1'b0;
            timer_int_reg <= 1'b0;
        end else begin
            count_reg     <= count_next;
            compare_reg   <= compare_next;
            status_reg    <= status_next;
            cause_reg     <= cause_next;
            epc_reg       <= epc_next;
            badvaddr_reg  <= badvaddr_next;
            phase_reg     <= phase_next;
            timer_int_reg <= timer_int_next;
        end
    end

    always_comb begin
        data_o = '0;
        if (!rst) begin
            case (raddr_i)
                ADDR_BADVADDR: data_o = badvaddr_reg;
                ADDR_COUNT:    data_o = count_reg;
                ADDR_COMPARE:  data_o = compare_reg;
                ADDR_STATUS:   data_o = status_reg;
                ADDR_CAUSE:    data_o = cause_reg;
                ADDR_EPC:      data_o = epc_reg;
                ADDR_PRID:     data_o = PRID_VALUE;
                ADDR_CONFIG:   data_o = CONFIG_VALUE;
                default:       data_o = '0;
            endcase
        end
    end

    assign status_o    = status_reg;
    assign cause_o     = cause_reg;
    assign epc_o       = epc_reg;
    assign count_o     = count_reg;
    assign compare_o   = compare_reg;
    assign badvaddr_o  = badvaddr_reg;
    assign timer_int_o = timer_int_reg;

endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: MTC0/MFC0 vector table plus hand-written timer and exception sequences.
module tb_cp0_reg;

`ifdef CP0_TIMER_INT_EN
    localparam logic TIMER_EN = 1'b1;
`else
    localparam logic TIMER_EN = 1'b0;
`endif

    localparam logic [31:0] PRID   = 32'h0000_4220;
    localparam logic [31:0] CONFIG = 32'h0000_8000;

    localparam int SEL_DATA = 0, SEL_STATUS = 1, SEL_CAUSE = 2, SEL_EPC = 3,
                   SEL_COUNT = 4, SEL_COMPARE = 5, SEL_BADV = 6, SEL_TIMER = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic [31:0] data_i = '0;
    logic [4:0]  raddr_i = '0;
    logic [31:0] data_o;
    logic [5:0]  int_i = '0;
    logic        exc_valid_i = 1'b0;
    logic [4:0]  exc_code_i = '0;
    logic [31:0] exc_pc_i = '0;
    logic        exc_in_ds_i = 1'b0;
    logic [31:0] bad_vaddr_i = '0;
    logic        eret_i = 1'b0;
    logic [31:0] status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
    logic        timer_int_o;

    int errors = 0;
    int checks = 0;

    cp0_reg dut (
        .clk(clk), .rst(rst), .we_i(we_i), .waddr_i(waddr_i), .data_i(data_i),
        .raddr_i(raddr_i), .data_o(data_o), .int_i(int_i),
        .exc_valid_i(exc_valid_i), .exc_code_i(exc_code_i), .exc_pc_i(exc_pc_i),
        .exc_in_ds_i(exc_in_ds_i), .bad_vaddr_i(bad_vaddr_i), .eret_i(eret_i),
        .status_o(status_o), .cause_o(cause_o), .epc_o(epc_o), .count_o(count_o),
        .compare_o(compare_o), .badvaddr_o(badvaddr_o), .timer_int_o(timer_int_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] mask;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic expect_out(input string name, input int sel, input logic [31:0] mask,
                              input logic [31:0] val);
        exp_t e;
        e.name = name; e.sel = sel; e.mask = mask; e.val = val;
        sb_q.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_DATA:    return data_o;
            SEL_STATUS:  return status_o;
            SEL_CAUSE:   return cause_o;
            SEL_EPC:     return epc_o;
            SEL_COUNT:   return count_o;
            SEL_COMPARE: return compare_o;
            SEL_BADV:    return badvaddr_o;
            default:     return {31'd0, timer_int_o};
        endcase
    endfunction

    // Compare all pending expectations at the falling edge.
    task automatic drain();
        exp_t        e;
        logic [31:0] act;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            act = observe(e.sel) & e.mask;
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end else begin
                $display("ok   %s: %h", e.name, act);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i = 1'b1; waddr_i = a; data_i = d;
        tick();
        we_i = 1'b0;
    endtask

    task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic ds,
                       input logic [31:0] bad);
        exc_valid_i = 1'b1; exc_code_i = code; exc_pc_i = pc;
        exc_in_ds_i = ds; bad_vaddr_i = bad;
        tick();
        exc_valid_i = 1'b0;
    endtask

    task automatic eret();
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] v);
        raddr_i = a;
        expect_out(name, SEL_DATA, 32'hFFFF_FFFF, v);
        drain();
    endtask

    initial begin
        vecs[0]  = '{5'd13, 32'hFFFF_FFFF, 5'd13, 32'h0000_0300};
        vecs[1]  = '{5'd13, 32'h0000_0000, 5'd13, 32'h0000_0000};
        vecs[2]  = '{5'd12, 32'hFFFF_FFFF, 5'd12, 32'h0040_FF03};
        vecs[3]  = '{5'd12, 32'h0000_0000, 5'd12, 32'h0000_0000};
        vecs[4]  = '{5'd14, 32'h1234_5678, 5'd14, 32'h1234_5678};
        vecs[5]  = '{5'd8,  32'hDEAD_BEEF, 5'd8,  32'h0000_0000};
        vecs[6]  = '{5'd15, 32'hFFFF_FFFF, 5'd15, PRID};
        vecs[7]  = '{5'd16, 32'h0000_0000, 5'd16, CONFIG};
        vecs[8]  = '{5'd11, 32'h0000_ABCD, 5'd11, 32'h0000_ABCD};
        vecs[9]  = '{5'd3,  32'h0000_0001, 5'd3,  32'h0000_0000};
        vecs[10] = '{5'd9,  32'h0000_1000, 5'd9,  32'h0000_1000};
        vecs[11] = '{5'd31, 32'h5A5A_5A5A, 5'd31, 32'h0000_0000};

        // Reset behaviour
        raddr_i = 5'd12;
        tick(); tick();
        expect_out("rst_data_zero", SEL_DATA, 32'hFFFF_FFFF, 32'h0);
        drain();
        rst = 1'b0;
        expect_out("rst_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h0040_0000);
        expect_out("rst_count", SEL_COUNT, 32'hFFFF_FFFF, 32'h0);
        expect_out("rst_compare", SEL_COMPARE, 32'hFFFF_FFFF, 32'h0);
        expect_out("rst_cause", SEL_CAUSE, 32'hFFFF_FFFF, 32'h0);
        expect_out("rst_epc", SEL_EPC, 32'hFFFF_FFFF, 32'h0);
        expect_out("rst_badv", SEL_BADV, 32'hFFFF_FFFF, 32'h0);
        expect_out("rst_timer", SEL_TIMER, 32'h1, 32'h0);
        drain();
        read_chk("rd12", 5'd12, 32'h0040_0000);
        read_chk("rd13", 5'd13, 32'h0);
        read_chk("rd14", 5'd14, 32'h0);
        read_chk("rd15", 5'd15, PRID);
        read_chk("rd3",  5'd3,  32'h0);

        // MTC0 masks and read-back
        for (int i = 0; i < 12; i++) begin
            mtc0(vecs[i].waddr, vecs[i].wdata);
            read_chk($sformatf("vec%0d_w%0d", i, vecs[i].waddr), vecs[i].raddr, vecs[i].exp);
        end

        // Count wrap with divide-by-2
        mtc0(5'd9, 32'hFFFF_FFFE);
        tick(); tick();
        expect_out("count_ffff", SEL_COUNT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        tick(); tick();
        expect_out("count_wrap", SEL_COUNT, 32'hFFFF_FFFF, 32'h0);
        drain();

        // Timer interrupt
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        expect_out("count_at5", SEL_COUNT, 32'hFFFF_FFFF, 32'd5);
        expect_out("timer_not_yet", SEL_TIMER, 32'h1, 32'h0);
        drain();
        tick();
        expect_out("timer_set", SEL_TIMER, 32'h1, {31'd0, TIMER_EN});
        expect_out("cause15_lag", SEL_CAUSE, 32'h0000_8000, 32'h0);
        drain();
        tick();
        expect_out("cause15_set", SEL_CAUSE, 32'h0000_8000, TIMER_EN ? 32'h0000_8000 : 32'h0);
        drain();
        tick(); tick(); tick(); tick();
        expect_out("timer_sticky", SEL_TIMER, 32'h1, {31'd0, TIMER_EN});
        drain();
        mtc0(5'd11, 32'd100);
        expect_out("timer_clear", SEL_TIMER, 32'h1, 32'h0);
        drain();

        // Interrupt line sampling
        int_i = 6'b10_0001;
        tick();
        expect_out("cause_ip", SEL_CAUSE, 32'h0000_FC00, 32'h0000_8400);
        drain();
        int_i = 6'b00_0000;

        // Exceptions
        mtc0(5'd12, 32'h0000_FF01);
        expect_out("status_ff01", SEL_STATUS, 32'hFFFF_FFFF, 32'h0000_FF01);
        drain();
        exc(5'd4, 32'hBFC0_0104, 1'b1, 32'h0000_1235);
        expect_out("exc1_epc", SEL_EPC, 32'hFFFF_FFFF, 32'hBFC0_0100);
        expect_out("exc1_bd", SEL_CAUSE, 32'h8000_0000, 32'h8000_0000);
        expect_out("exc1_code", SEL_CAUSE, 32'h0000_007C, 32'h0000_0010);
        expect_out("exc1_exl", SEL_STATUS, 32'h0000_0002, 32'h0000_0002);
        expect_out("exc1_badv", SEL_BADV, 32'hFFFF_FFFF, 32'h0000_1235);
        drain();
        read_chk("exc1_rd14", 5'd14, 32'hBFC0_0100);
        exc(5'd0, 32'h0000_0080, 1'b0, 32'h0000_9999);
        expect_out("exc2_epc_keep", SEL_EPC, 32'hFFFF_FFFF, 32'hBFC0_0100);
        expect_out("exc2_bd_keep", SEL_CAUSE, 32'h8000_0000, 32'h8000_0000);
        expect_out("exc2_code", SEL_CAUSE, 32'h0000_007C, 32'h0);
        expect_out("exc2_badv_keep", SEL_BADV, 32'hFFFF_FFFF, 32'h0000_1235);
        drain();
        we_i = 1'b1; waddr_i = 5'd14; data_i = 32'h5555_5555;
        eret();
        we_i = 1'b0;
        expect_out("eret_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h0000_FF01);
        expect_out("eret_mtc0_drop", SEL_EPC, 32'hFFFF_FFFF, 32'hBFC0_0100);
        drain();
        exc(5'd5, 32'h0000_0400, 1'b0, 32'h0000_ABC0);
        expect_out("exc3_epc", SEL_EPC, 32'hFFFF_FFFF, 32'h0000_0400);
        expect_out("exc3_bd", SEL_CAUSE, 32'h8000_0000, 32'h0);
        expect_out("exc3_code", SEL_CAUSE, 32'h0000_007C, 32'h0000_0014);
        expect_out("exc3_badv", SEL_BADV, 32'hFFFF_FFFF, 32'h0000_ABC0);
        expect_out("exc3_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h0000_FF03);
        drain();
        eret();

        // Exception, ERET and MTC0 together
        we_i = 1'b1; waddr_i = 5'd12; data_i = 32'h0;
        eret_i = 1'b1;
        exc(5'd0, 32'h0000_0200, 1'b0, 32'h0);
        we_i = 1'b0; eret_i = 1'b0;
        expect_out("prio_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h0000_FF03);
        expect_out("prio_epc", SEL_EPC, 32'hFFFF_FFFF, 32'h0000_0200);
        drain();

        // Status mask then ERET
        mtc0(5'd12, 32'hFFFF_FFFF);
        read_chk("status_all1", 5'd12, 32'h0040_FF03);
        eret();
        read_chk("status_eret", 5'd12, 32'h0040_FF01);

        // Reset mid-run
        rst = 1'b1;
        raddr_i = 5'd12;
        tick();
        expect_out("rst2_data", SEL_DATA, 32'hFFFF_FFFF, 32'h0);
        expect_out("rst2_status", SEL_STATUS, 32'hFFFF_FFFF, 32'h0040_0000);
        expect_out("rst2_count", SEL_COUNT, 32'hFFFF_FFFF, 32'h0);
        expect_out("rst2_epc", SEL_EPC, 32'hFFFF_FFFF, 32'h0);
        expect_out("rst2_compare", SEL_COMPARE, 32'hFFFF_FFFF, 32'h0);
        drain();
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
